mem_step_arbiter: RTL and testbench

Sequencer that shares one single-port unified memory between the core's instruction-fetch port and data-access port. It sits between the five-stage core and the memory. For every pipeline step it collects the fetch and/or load/store request, serialises them onto the memory bus (data first, then fetch), and buffers the read results. It holds the core's `stall_n` low until every request of the step has completed, and it aborts any access that exceeds a watchdog limit.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_watchdog.sv | 40 ++++
 rtl/mem_step_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_step_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory step arbiter.
// Holds the arbiter FSM states and the memory access-size encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_mode_t;

    localparam logic [1:0] MODE_WORD = MEM_WORD;

endpackage

// File: rtl/arb_watchdog.sv
// Clearable saturating wait counter for one memory access.
// Ports: clk, rst, clr (restart), inc (waiting), expired (limit hit now).
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Fires in the cycle whose increment would bring the count to the
    // limit, so the request is held for exactly TIMEOUT_CYCLES cycles.
    assign expired = inc && (cnt_q >= LIMIT - CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_step_arbiter.sv
// Serialises one pipeline step's data and fetch accesses onto a single memory.
// Ports: core side i_*/d_*/stall_n, memory side m_*, sticky timeout err.
module mem_step_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int MODE_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [WORD_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    input  logic [MODE_WIDTH-1:0] d_mode,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  stall_n,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WORD_WIDTH-1:0] m_wdata,
    output logic [MODE_WIDTH-1:0] m_mode,
    input  logic [WORD_WIDTH-1:0] m_rdata,
    input  logic                  m_ack,
    output logic                  err
);

    arb_state_t state_q, state_d;

    logic                  i_req_q, i_req_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic [WORD_WIDTH-1:0] d_wdata_q, d_wdata_d;
    logic [MODE_WIDTH-1:0] d_mode_q, d_mode_d;
    logic [WORD_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;

    logic any_req;
    logic in_d;
    logic in_i;
    logic in_acc;
    logic acked;
    logic wd_exp;
    logic finish;
    logic [WORD_WIDTH-1:0] rd_val;

    assign any_req = i_req | d_read | d_write;
    assign in_d    = (state_q == D_ACC);
    assign in_i    = (state_q == I_ACC);
    assign in_acc  = in_d | in_i;
    assign acked   = in_acc & m_ack;
    // An ack in the limit cycle wins because inc already excludes it.
    assign finish  = acked | wd_exp;
    assign rd_val  = acked ? m_rdata : '0;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_d != state_q),
        .inc    (in_acc & ~m_ack),
        .expired(wd_exp)
    );

    always_comb begin
        state_d   = state_q;
        i_req_d   = i_req_q;
        i_addr_d  = i_addr_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_mode_d  = d_mode_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q | wd_exp;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    i_req_d   = i_req;
                    i_addr_d  = i_addr;
                    rd_d      = d_read;
                    wr_d      = d_write;
                    d_addr_d  = d_addr;
                    d_wdata_d = d_wdata;
                    d_mode_d  = d_mode;
                    state_d   = (d_read | d_write) ? D_ACC : I_ACC;
                end
            end
            D_ACC: begin
                if (finish) begin
                    if (rd_q) begin
                        d_rdata_d = rd_val;
                    end
                    state_d = i_req_q ? I_ACC : DONE;
                end
            end
            I_ACC: begin
                if (finish) begin
                    i_rdata_d = rd_val;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_req_q   <= 1'b0;
            i_addr_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_mode_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_req_q   <= i_req_d;
            i_addr_q  <= i_addr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_mode_q  <= d_mode_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // stall_n drops in the very cycle a request appears so the core
    // cannot advance past a step that has not been served yet.
    assign stall_n = ~(in_acc | ((state_q == IDLE) & any_req));
    assign m_req   = in_acc;
    assign m_we    = in_d & wr_q;
    assign m_addr  = in_d ? d_addr_q : (in_i ? i_addr_q : '0);
    assign m_wdata = in_d ? d_wdata_q : '0;
    assign m_mode  = in_d ? d_mode_q :
                     (in_i ? MODE_WIDTH'(MODE_WORD) : '0);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_step_arbiter.sv
// Scoreboard bench for mem_step_arbiter with a randomised memory model.
// Expected accesses and step results are queued by stimulus, popped by monitors.
module tb_mem_step_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_mode;
    logic [31:0] d_rdata;
    logic        stall_n;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_mode;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;

    always #5 clk = ~clk;

    mem_step_arbiter #(
        .ADDR_WIDTH(32),
        .WORD_WIDTH(32),
        .MODE_WIDTH(2),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_mode(d_mode), .d_rdata(d_rdata),
        .stall_n(stall_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_mode(m_mode),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  mode;
        int          wt;
        logic [31:0] rdata;
    } acc_t;

    typedef struct {
        int          low;
        logic [31:0] ir;
        logic [31:0] dr;
        logic        er;
    } step_t;

    acc_t  acc_q[$];
    step_t step_q[$];

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;
    logic        exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Memory model: answers each access after its planned number of
    // wait cycles and checks every cycle of the presented request.
    initial begin
        int   cnt;
        bit   active;
        acc_t cur;
        cnt = 0;
        active = 0;
        cur = '{addr: 0, we: 0, wdata: 0, mode: 0, wt: 0, rdata: 0};
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (m_req !== 1'b1) begin
                active = 0;
                cnt = 0;
                m_ack = ($urandom_range(0, 3) == 0);
                m_rdata = $urandom;
            end else begin
                if (!active) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_access addr=%h expected none",
                                 m_addr);
                        cur = '{addr: m_addr, we: m_we, wdata: m_wdata,
                                mode: m_mode, wt: 0, rdata: 0};
                    end else begin
                        cur = acc_q.pop_front();
                    end
                    active = 1;
                    cnt = 0;
                end
                chk("m_addr", m_addr, cur.addr);
                chk("m_we", {31'd0, m_we}, {31'd0, cur.we});
                chk("m_mode", {30'd0, m_mode}, {30'd0, cur.mode});
                if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
                m_ack = (cnt == cur.wt);
                m_rdata = m_ack ? cur.rdata : $urandom;
                cnt++;
                if (m_ack || cnt == T) active = 0;
            end
        end
    end

    // Step monitor: counts stalled cycles and checks results in DONE.
    initial begin
        int    low;
        step_t s;
        low = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low = 0;
            end else if (!stall_n) begin
                low++;
            end else if (low > 0) begin
                if (step_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=step expected=none");
                end else begin
                    s = step_q.pop_front();
                    chk("stall_low", low, s.low);
                    chk("i_rdata", i_rdata, s.ir);
                    chk("d_rdata", d_rdata, s.dr);
                    chk("err", {31'd0, err}, {31'd0, s.er});
                end
                low = 0;
            end
        end
    end

    task automatic clear_in();
        i_req = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        d_mode = '0;
    endtask

    task automatic scramble();
        i_req = 1'($urandom);
        d_read = 1'($urandom);
        d_write = ~d_read & 1'($urandom);
        i_addr = $urandom;
        d_addr = $urandom;
        d_wdata = $urandom;
        d_mode = 2'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Caller is at posedge+2 of an idle cycle.
    task automatic step(input bit ir, input bit rd, input bit wr,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [1:0] md,
                        input int dwt, input logic [31:0] drd,
                        input int iwt, input logic [31:0] ird);
        int   low;
        bit   done;
        acc_t a;
        low = 1;
        if (rd || wr) begin
            a = '{addr: da, we: wr, wdata: wd, mode: md,
                  wt: dwt, rdata: drd};
            acc_q.push_back(a);
            low += (dwt >= T) ? T : dwt + 1;
            if (dwt >= T) exp_err = 1'b1;
            if (rd) exp_d = (dwt >= T) ? 32'd0 : drd;
        end
        if (ir) begin
            a = '{addr: ia, we: 1'b0, wdata: 0, mode: 2'd2,
                  wt: iwt, rdata: ird};
            acc_q.push_back(a);
            low += (iwt >= T) ? T : iwt + 1;
            if (iwt >= T) exp_err = 1'b1;
            exp_i = (iwt >= T) ? 32'd0 : ird;
        end
        step_q.push_back('{low: low, ir: exp_i, dr: exp_d, er: exp_err});
        i_req = ir;
        d_read = rd;
        d_write = wr;
        i_addr = ia;
        d_addr = da;
        d_wdata = wd;
        d_mode = md;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (k > 0 && stall_n) done = 1;
            @(posedge clk);
            #2;
            if (done) clear_in();
            else scramble();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL step_timeout actual=no_done expected=done");
            clear_in();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global time limit");
    end

    initial begin
        bit ir, rd, wr;
        int sel;
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_stall_n", {31'd0, stall_n}, 32'd1);
            chk("rst_m_req", {31'd0, m_req}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
        end
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        @(posedge clk);
        #2;

        step(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 32'h00500093);
        idle(1);
        step(1, 0, 1, 32'h104, 32'h2000, 32'hDEADBEEF, 2'd2,
             2, 0, 2, 32'h00000013);
        idle(2);
        step(0, 1, 0, 0, 32'h2004, 0, 2'd2, T - 1, 32'hCAFEF00D, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 32'h3000, 0, 2'd2, 99, 32'h12345678, 0, 0);
        idle(1);
        step(1, 1, 0, 32'h108, 32'h2008, 0, 2'd1, 1, 32'h0000BEEF,
             0, 32'h00100073);
        step(1, 0, 0, 32'h10C, 0, 0, 0, 2, 0, 1, 32'h00A00513);
        idle(1);

        // Reset while the fetch access is still waiting on memory.
        acc_q.push_back('{addr: 32'h140, we: 1'b0, wdata: 0, mode: 2'd2,
                          wt: 99, rdata: 0});
        i_req = 1'b1;
        i_addr = 32'h140;
        @(posedge clk);
        #2;
        i_addr = 32'hFFFF_0000;
        d_addr = 32'h0BAD_0000;
        @(negedge clk);
        chk("hold_m_addr", m_addr, 32'h140);
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("mid_rst_m_req", {31'd0, m_req}, 32'd0);
        chk("mid_rst_stall_n", {31'd0, stall_n}, 32'd1);
        chk("mid_rst_m_addr", m_addr, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_i_rdata", i_rdata, 32'd0);
        chk("mid_rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        acc_q.delete();
        step_q.delete();
        exp_i = '0;
        exp_d = '0;
        exp_err = 1'b0;
        idle(1);

        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom);
            sel = $urandom_range(0, 2);
            rd = (sel == 1);
            wr = (sel == 2);
            if (!ir && !rd && !wr) ir = 1'b1;
            step(ir, rd, wr, $urandom, $urandom, $urandom, 2'($urandom),
                 $urandom_range(0, 5), $urandom,
                 $urandom_range(0, 5), $urandom);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("step_q_drained", step_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
